// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, opcodes, control-bundle bit indices and immediate formats
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_JALR     = 1;
    localparam int CTRL_PCREL    = 0;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate from instruction bits [31:7] and a format select
//   instr  in   instruction bits [31:7] (opcode not needed)
//   sel    in   immediate format
//   imm    out  XLEN-bit immediate (B/J have bit0=0, IMM_NONE gives 0)
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [31:7]     instr,
    input  imm_t            sel,
    output logic [XLEN-1:0] imm
);
    logic s;
    assign s = instr[31];

    assign imm = sel == IMM_I ? {{(XLEN-11){s}}, instr[30:20]} :
                 sel == IMM_S ? {{(XLEN-11){s}}, instr[30:25], instr[11:7]} :
                 sel == IMM_B ? {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                 sel == IMM_U ? {{(XLEN-31){s}}, instr[30:12], 12'b0} :
                 sel == IMM_J ? {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                 '0;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode, WB bypass, load-use hazard detection and ID/EX register
//   IF/ID side : if_valid, if_instr, if_pc in; id_ready out (0 = stall IF/ID and PC)
//   flush      : kill the ID instruction, bubble into EX
//   regfile    : rf_rs1/rf_rs2 addresses out, rf_rd1/rf_rd2 data in
//   WB bypass  : wb_we, wb_rd, wb_data
//   EX side    : registered ex_* bundle, ex_illegal pulses when an unknown opcode is dropped
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW,
    parameter int CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_rs1,
    output logic [REG_AW-1:0] rf_rs2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_illegal
);
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              legal, uses_rs1, uses_rs2;
    logic [CTRL_W-1:0] ctrl;
    imm_t              imm_sel;
    logic [XLEN-1:0]   imm, op1, op2;
    logic              hazard, accept, load;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    always_comb begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        ctrl     = '0;
        imm_sel  = IMM_NONE;
        case (opcode)
            OP_LUI: begin
                uses_rs1 = 1'b0;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_sel = IMM_U;
            end
            OP_AUIPC: begin
                uses_rs1 = 1'b0;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_PCREL]    = 1'b1;
                imm_sel = IMM_U;
            end
            OP_JAL: begin
                uses_rs1 = 1'b0;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                ctrl[CTRL_PCREL]    = 1'b1;
                imm_sel = IMM_J;
            end
            OP_JALR: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                ctrl[CTRL_JALR]     = 1'b1;
                imm_sel = IMM_I;
            end
            OP_BRANCH: begin
                uses_rs2 = 1'b1;
                ctrl[CTRL_BRANCH] = 1'b1;
                ctrl[CTRL_PCREL]  = 1'b1;
                imm_sel = IMM_B;
            end
            OP_LOAD: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_sel = IMM_I;
            end
            OP_STORE: begin
                uses_rs2 = 1'b1;
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_sel = IMM_S;
            end
            OP_IMM: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_sel = IMM_I;
            end
            OP_OP: begin
                uses_rs2 = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
            end
            default: begin
                // an unknown opcode reads nothing, so it can never trigger a stall
                legal    = 1'b0;
                uses_rs1 = 1'b0;
            end
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr[31:7]),
        .sel   (imm_sel),
        .imm   (imm)
    );

    // WB writes the register file this same cycle, so its data is newer than rf_rd*
    assign op1 = rs1 == '0 ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_rd1;
    assign op2 = rs2 == '0 ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_rd2;

    // a load in EX has no data until MEM; one bubble is enough
    assign hazard = ex_valid && ex_ctrl[CTRL_MEMREAD] && ex_rd != '0 && if_valid &&
                    ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));

    assign id_ready = reset && (flush || !hazard);
    assign accept   = if_valid && id_ready && !flush;
    assign load     = accept && legal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_ctrl     <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            ex_valid    <= load;
            ex_pc       <= load ? if_pc : '0;
            ex_rs1_val  <= load ? op1 : '0;
            ex_rs2_val  <= load ? op2 : '0;
            ex_imm      <= load ? imm : '0;
            ex_rs1      <= load ? rs1 : '0;
            ex_rs2      <= load ? rs2 : '0;
            ex_rd       <= (load && ctrl[CTRL_REGWRITE]) ? rd : '0;
            ex_funct3   <= load ? if_instr[14:12] : '0;
            ex_funct7b5 <= load && if_instr[30];
            ex_ctrl     <= load ? ctrl : '0;
            ex_illegal  <= accept && !legal;
        end
    end
endmodule
